uart_rx_byte: RTL and testbench

- Asynchronous serial receiver, 8N1 format (8 data bits, no parity, 1 stop bit), LSB first.
- Directly upstream of uart_input_handler: its byte/byte_available outputs drive that handler's byte and byte_available inputs.
- Turns the raw rx pin into one-cycle byte strobes and flags framing errors.
- Clock-divider based; samples each bit at its midpoint.

---
 rtl/uart_rx_byte_pkg.sv | 23 ++
 rtl/uart_rx_sync.sv | 33 +++
 rtl/uart_rx_byte.sv | 144 ++++++++++++++
 tb/tb_uart_rx_byte.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_byte_pkg.sv
// ============================================================================
// Module : uart_rx_byte_pkg
// Brief  : Shared state encoding and default bit timing for the UART receiver.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_rx_byte_pkg;

    // 50 MHz system clock, 115200 baud
    localparam int DEFAULT_CLKS_PER_BIT = 434;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_HIGH = 3'd4
    } rx_state_e;

endpackage

`default_nettype wire

// File: rtl/uart_rx_sync.sv
// ============================================================================
// Module : uart_rx_sync
// Brief  : Two-flop synchronizer for an idle-high serial line; resets to 1.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Reset to the idle level so release never looks like a start bit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

`default_nettype wire

// File: rtl/uart_rx_byte.sv
// ============================================================================
// Module : uart_rx_byte
// Brief  : 8N1 UART receiver, mid-bit sampling, byte and framing-error strobes.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_byte
    import uart_rx_byte_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int CNT_WIDTH    = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_i,
    output logic [7:0] byte_o,
    output logic       byte_available_o,
    output logic       framing_error_o,
    output logic       busy_o
);

    localparam logic [CNT_WIDTH-1:0] HALF_M1 = CNT_WIDTH'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_WIDTH-1:0] BIT_M1  = CNT_WIDTH'(CLKS_PER_BIT - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    logic                 rx_s;
    rx_state_e            state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [2:0]           bit_idx_q, bit_idx_d;
    logic [7:0]           shift_q, shift_d;
    logic [7:0]           byte_q, byte_d;
    logic                 avail_q, avail_d;
    logic                 ferr_q, ferr_d;

    uart_rx_sync u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (rx_i),
        .q_o (rx_s)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            byte_q    <= '0;
            avail_q   <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            byte_q    <= byte_d;
            avail_q   <= avail_d;
            ferr_q    <= ferr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        byte_d    = byte_q;
        avail_d   = 1'b0;
        ferr_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (!rx_s) begin
                    state_d = ST_START;
                end
            end

            // Re-check the start bit at its midpoint to reject line glitches
            ST_START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d = '0;
                    if (!rx_s) begin
                        state_d   = ST_DATA;
                        bit_idx_d = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            ST_DATA: begin
                if (cnt_q == BIT_M1) begin
                    cnt_d     = '0;
                    shift_d   = {rx_s, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = ST_STOP;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            ST_STOP: begin
                if (cnt_q == BIT_M1) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        byte_d  = shift_q;
                        avail_d = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = ST_WAIT_HIGH;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            // A held-low break must clear before another start bit is accepted
            ST_WAIT_HIGH: begin
                if (rx_s) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign byte_o           = byte_q;
    assign byte_available_o = avail_q;
    assign framing_error_o  = ferr_q;
    assign busy_o           = (state_q != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_byte.sv
// ============================================================================
// Module : tb_uart_rx_byte
// Brief  : Directed plus randomized frames checked against a frame-level model.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_uart_rx_byte;

    localparam int CPB  = 8;
    localparam int HALF = CPB / 2;
    localparam int LAT  = 2 + HALF + 9 * CPB + 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic [7:0] byte_o;
    logic       byte_available_o;
    logic       framing_error_o;
    logic       busy_o;

    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] exp_byte = 8'h00;

    uart_rx_byte #(
        .CLKS_PER_BIT (CPB),
        .CNT_WIDTH    (16)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .rx_i             (rx),
        .byte_o           (byte_o),
        .byte_available_o (byte_available_o),
        .framing_error_o  (framing_error_o),
        .busy_o           (busy_o)
    );

    always #2 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Line idle high: nothing may happen and the last good byte must hold
    task automatic idle(input int n);
        rx = 1'b1;
        for (int i = 0; i < n; i++) begin
            tick();
            check("idle_avail", {7'd0, byte_available_o}, 8'h00);
            check("idle_ferr", {7'd0, framing_error_o}, 8'h00);
            check("idle_busy", {7'd0, busy_o}, 8'h00);
            check("idle_byte", byte_o, exp_byte);
        end
    endtask

    // Drives start, 8 data bits LSB first, stop; the strobe lands inside the stop bit
    task automatic send_frame(input logic [7:0] d, input logic stop_ok);
        logic [9:0] bits;
        int         c;
        bits = {stop_ok, d, 1'b0};
        for (int k = 0; k < 10 * CPB; k++) begin
            rx = bits[k / CPB];
            tick();
            c = k + 1;
            check("avail", {7'd0, byte_available_o}, {7'd0, (c == LAT) && stop_ok});
            check("ferr", {7'd0, framing_error_o}, {7'd0, (c == LAT) && !stop_ok});
            if (c == LAT && stop_ok) begin
                check("byte", byte_o, d);
            end
            if (c == 40) begin
                check("busy_mid", {7'd0, busy_o}, 8'h01);
            end
            if (c == LAT + 1) begin
                check("busy_after", {7'd0, busy_o}, {7'd0, !stop_ok});
            end
        end
        if (stop_ok) begin
            exp_byte = d;
        end
        check("byte_hold", byte_o, exp_byte);
    endtask

    // Break after a bad stop bit: busy holds, then clears 3 edges after release
    task automatic hold_low_then_release(input int n);
        rx = 1'b0;
        for (int i = 0; i < n; i++) begin
            tick();
            check("brk_busy", {7'd0, busy_o}, 8'h01);
            check("brk_ferr", {7'd0, framing_error_o}, 8'h00);
            check("brk_avail", {7'd0, byte_available_o}, 8'h00);
        end
        rx = 1'b1;
        tick();
        tick();
        check("brk_busy_sync", {7'd0, busy_o}, 8'h01);
        tick();
        check("brk_busy_clear", {7'd0, busy_o}, 8'h00);
        check("brk_byte", byte_o, exp_byte);
    endtask

    initial begin
        int         gap;
        logic [7:0] d;
        logic       ok;
        logic [9:0] bits;
        int         seen;

        #1;
        check("rst_byte", byte_o, 8'h00);
        check("rst_avail", {7'd0, byte_available_o}, 8'h00);
        check("rst_ferr", {7'd0, framing_error_o}, 8'h00);
        check("rst_busy", {7'd0, busy_o}, 8'h00);
        tick();
        tick();
        rst = 1'b0;

        idle(1000);

        send_frame(8'h55, 1'b1);
        idle(5);

        // Short low glitch must be rejected at the start-bit midpoint
        rx = 1'b0;
        tick();
        tick();
        rx = 1'b1;
        seen = 0;
        for (int i = 0; i < HALF + 3; i++) begin
            tick();
            if (byte_available_o || framing_error_o) seen++;
        end
        check("glitch_strobes", seen[7:0], 8'h00);
        check("glitch_busy", {7'd0, busy_o}, 8'h00);
        check("glitch_byte", byte_o, 8'h55);
        idle(5);

        send_frame(8'h55, 1'b1);
        send_frame(8'hA3, 1'b0);
        hold_low_then_release(30);
        idle(3);
        send_frame(8'hA3, 1'b1);
        idle(4);

        send_frame(8'h4C, 1'b1);
        send_frame(8'h30, 1'b1);
        idle(4);

        for (int n = 0; n < 8; n++) begin
            d   = 8'($urandom);
            ok  = ($urandom_range(0, 3) != 0);
            gap = $urandom_range(0, 20);
            send_frame(d, ok);
            if (!ok) begin
                hold_low_then_release($urandom_range(1, 30));
            end
            idle(gap);
        end

        // Abort a frame after its 4th data bit with an asynchronous reset
        bits = {1'b1, 8'hC3, 1'b0};
        for (int k = 0; k < 5 * CPB + 3; k++) begin
            rx = bits[k / CPB];
            tick();
        end
        check("mid_busy", {7'd0, busy_o}, 8'h01);
        rx  = 1'b1;
        rst = 1'b1;
        #1;
        check("arst_byte", byte_o, 8'h00);
        check("arst_avail", {7'd0, byte_available_o}, 8'h00);
        check("arst_ferr", {7'd0, framing_error_o}, 8'h00);
        check("arst_busy", {7'd0, busy_o}, 8'h00);
        exp_byte = 8'h00;
        tick();
        tick();
        rst = 1'b0;
        idle(20);
        send_frame(8'hFF, 1'b1);
        idle(10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
